// File: rtl/mix_round_checker.sv
// +----------------------------------------------------------------------------+
// | mix_round_checker: receive-side checker for the 8x32-bit mixing-round      |
// | stream; recomputes each round one update per cycle and flags mismatches.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mix_round_checker #(
  parameter int RCW    = 16,
  parameter bit RESYNC = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [31:0]    in_data,
  output logic           in_ready,
  output logic           busy,
  output logic           round_done,
  output logic           round_ok,
  output logic           err_sticky,
  output logic [2:0]     err_word_idx,
  output logic [RCW-1:0] round_cnt
);

  typedef enum logic [0:0] {
    ST_COMPUTE = 1'b0,
    ST_RECV    = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     step_q, step_d;
  logic [31:0]    o_q [8];
  logic [31:0]    o_d [8];
  logic [2:0]     wcnt_q, wcnt_d;
  logic [7:0]     mask_q, mask_d;
  logic           done_q, done_d;
  logic           ok_q, ok_d;
  logic           sticky_q, sticky_d;
  logic [2:0]     idx_q, idx_d;
  logic [RCW-1:0] cnt_q, cnt_d;

  logic [2:0]  cur, ip1, ip2, ip3, ip4, ip5, im1, im2;
  logic [31:0] upd;
  logic [7:0]  mask_new;
  logic        accept;

  function automatic logic [31:0] mul_a(input logic [2:0] k);
    case (k)
      3'd0: mul_a = 32'd2;   3'd1: mul_a = 32'd3;
      3'd2: mul_a = 32'd5;   3'd3: mul_a = 32'd7;
      3'd4: mul_a = 32'd11;  3'd5: mul_a = 32'd13;
      3'd6: mul_a = 32'd17;  default: mul_a = 32'd19;
    endcase
  endfunction

  function automatic logic [31:0] add_b(input logic [2:0] k);
    case (k)
      3'd0: add_b = 32'd3;   3'd1: add_b = 32'd5;
      3'd2: add_b = 32'd7;   3'd3: add_b = 32'd11;
      3'd4: add_b = 32'd13;  3'd5: add_b = 32'd17;
      3'd6: add_b = 32'd19;  default: add_b = 32'd23;
    endcase
  endfunction

  function automatic logic [31:0] mul_c(input logic [2:0] k);
    case (k)
      3'd0: mul_c = 32'd2;   3'd1: mul_c = 32'd3;
      3'd2: mul_c = 32'd3;   3'd3: mul_c = 32'd3;
      3'd4: mul_c = 32'd5;   3'd5: mul_c = 32'd13;
      3'd6: mul_c = 32'd35;  default: mul_c = 32'd87;
    endcase
  endfunction

  function automatic logic [31:0] add_d(input logic [2:0] k);
    case (k)
      3'd0: add_d = 32'd0;   3'd1: add_d = 32'd1;
      3'd2: add_d = 32'd8;   3'd3: add_d = 32'd27;
      3'd4: add_d = 32'd64;  3'd5: add_d = 32'd125;
      3'd6: add_d = 32'd216; default: add_d = 32'd343;
    endcase
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) lowest_set = 3'(k);
    end
  endfunction

  // Neighbour indices wrap naturally in 3 bits.
  assign cur = step_q[2:0];
  assign ip1 = cur + 3'd1;
  assign ip2 = cur + 3'd2;
  assign ip3 = cur + 3'd3;
  assign ip4 = cur + 3'd4;
  assign ip5 = cur + 3'd5;
  assign im1 = cur - 3'd1;
  assign im2 = cur - 3'd2;

  assign in_ready     = (state_q == ST_RECV);
  assign busy         = (state_q == ST_COMPUTE);
  assign accept       = in_valid && in_ready;
  assign round_done   = done_q;
  assign round_ok     = ok_q;
  assign err_sticky   = sticky_q;
  assign err_word_idx = idx_q;
  assign round_cnt    = cnt_q;

  always_comb begin
    upd = o_q[cur];
    case (step_q[5:3])
      3'd0:    upd = o_q[cur] + {29'd0, cur};
      3'd1:    upd = o_q[cur] + o_q[im1];
      3'd2:    upd = o_q[cur] + o_q[ip1] - o_q[ip5];
      3'd3:    upd = o_q[cur] ^ (o_q[ip3] << 16);
      3'd4:    upd = o_q[cur] - (o_q[ip2] >> 17) + (o_q[ip4] >> 12);
      3'd5:    upd = o_q[cur] + o_q[im1] - o_q[im2];
      3'd6:    upd = o_q[cur] * mul_a(cur) + add_b(cur);
      default: upd = o_q[cur] * mul_c(cur) + add_d(cur);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    o_d      = o_q;
    wcnt_d   = wcnt_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    sticky_d = sticky_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mask_new = mask_q | (8'(in_data != o_q[wcnt_q]) << wcnt_q);
    case (state_q)
      ST_COMPUTE: begin
        o_d[cur] = upd;
        step_d   = step_q + 6'd1;
        if (step_q == 6'd63) state_d = ST_RECV;
      end
      default: begin
        if (accept) begin
          mask_d = mask_new;
          wcnt_d = wcnt_q + 3'd1;
          // Word k is only compared against slot k, so a resyncing checker can
          // overwrite each slot as its word arrives.
          if (RESYNC) o_d[wcnt_q] = in_data;
          if (wcnt_q == 3'd7) begin
            state_d = ST_COMPUTE;
            step_d  = 6'd0;
            mask_d  = 8'd0;
            done_d  = 1'b1;
            ok_d    = (mask_new == 8'd0);
            cnt_d   = cnt_q + RCW'(1);
            if (mask_new != 8'd0) begin
              sticky_d = 1'b1;
              idx_d    = lowest_set(mask_new);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_COMPUTE;
      step_q   <= 6'd0;
      for (int k = 0; k < 8; k++) o_q[k] <= 32'(k);
      wcnt_q   <= 3'd0;
      mask_q   <= 8'd0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      sticky_q <= 1'b0;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      o_q      <= o_d;
      wcnt_q   <= wcnt_d;
      mask_q   <= mask_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      sticky_q <= sticky_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mix_round_checker.sv
// +----------------------------------------------------------------------------+
// | tb_mix_round_checker: directed bench for mix_round_checker.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mix_round_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready, busy, round_done, round_ok, err_sticky;
  logic [2:0]  err_word_idx;
  logic [15:0] round_cnt;
  logic        in_ready2, busy2, round_done2, round_ok2, err_sticky2;
  logic [2:0]  err_word_idx2;
  logic [1:0]  round_cnt2;

  mix_round_checker #(.RCW(16), .RESYNC(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .round_done(round_done),
    .round_ok(round_ok), .err_sticky(err_sticky),
    .err_word_idx(err_word_idx), .round_cnt(round_cnt)
  );

  mix_round_checker #(.RCW(2), .RESYNC(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .busy(busy2), .round_done(round_done2),
    .round_ok(round_ok2), .err_sticky(err_sticky2),
    .err_word_idx(err_word_idx2), .round_cnt(round_cnt2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  logic [31:0] ka [8] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  logic [31:0] kb [8] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  logic [31:0] kc [8] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  logic [31:0] kd [8] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

  logic [31:0] gold [5][8];
  logic [31:0] m  [8];
  logic [31:0] tx [8];

  always @(posedge clk) begin
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (round_done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference round: each update sees the values written earlier in the sweep.
  task automatic model_round();
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 8; i++) begin
        case (s)
          0: m[i] = m[i] + 32'(i);
          1: m[i] = m[i] + m[(i+7)%8];
          2: m[i] = m[i] + m[(i+1)%8] - m[(i+5)%8];
          3: m[i] = m[i] ^ (m[(i+3)%8] << 16);
          4: m[i] = m[i] - (m[(i+2)%8] >> 17) + (m[(i+4)%8] >> 12);
          5: m[i] = m[i] + m[(i+7)%8] - m[(i+6)%8];
          6: m[i] = m[i] * ka[i] + kb[i];
          default: m[i] = m[i] * kc[i] + kd[i];
        endcase
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd1);
    check_val("rst_round_done", 32'(round_done), 32'd0);
    check_val("rst_round_ok", 32'(round_ok), 32'd0);
    check_val("rst_err_sticky", 32'(err_sticky), 32'd0);
    check_val("rst_err_idx", 32'(err_word_idx), 32'd0);
    check_val("rst_round_cnt", 32'(round_cnt), 32'd0);
    check_val("rst_round_cnt2", 32'(round_cnt2), 32'd0);
    rst = 1'b0;
  endtask

  task automatic send_round(input int nw, input bit gaps, input bit hold);
    int n;
    for (int k = 0; k < nw; k++) begin
      if (gaps && k > 0) begin
        n = int'($urandom_range(0, 3));
        if (n > 0) begin
          in_valid = 1'b0;
          repeat (n) @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = tx[k];
      n = 0;
      while (!in_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        check_val("send_ready", 32'(in_ready), 32'd1);
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Called at the negedge following the 8th accept.
  task automatic finish_round(input bit exp_ok, input bit chk_idx, input logic [2:0] exp_idx,
                              input bit exp_sticky, input int exp_cnt);
    int n;
    check_val("round_done", 32'(round_done), 32'd1);
    check_val("ready_drop", 32'(in_ready), 32'd0);
    check_val("round_ok", 32'(round_ok), 32'(exp_ok));
    check_val("err_sticky", 32'(err_sticky), 32'(exp_sticky));
    check_val("round_cnt", 32'(round_cnt), 32'(exp_cnt));
    if (chk_idx) check_val("err_word_idx", 32'(err_word_idx), 32'(exp_idx));
    wait_ready(n);
    check_val("done_to_ready", 32'(n), 32'd64);
  endtask

  initial begin
    int n;
    int acc0, done0;
    for (int i = 0; i < 8; i++) m[i] = 32'(i);
    for (int r = 0; r < 5; r++) begin
      model_round();
      for (int i = 0; i < 8; i++) gold[r][i] = m[i];
    end

    // T1: reset, then idle COMPUTE of exactly 64 cycles
    do_reset();
    done0 = done_cnt;
    wait_ready(n);
    check_val("t1_busy_cycles", 32'(n), 32'd64);
    check_val("t1_busy_low", 32'(busy), 32'd0);
    check_val("t1_ready", 32'(in_ready), 32'd1);
    check_val("t1_no_done", 32'(done_cnt - done0), 32'd0);

    // T2: golden round 1
    for (int i = 0; i < 8; i++) tx[i] = gold[0][i];
    send_round(8, 1'b0, 1'b0);
    finish_round(1'b1, 1'b1, 3'd0, 1'b0, 1);

    // T3: round 2 with word 5 flipped, then golden round 3 from corrupted seed
    for (int i = 0; i < 8; i++) tx[i] = gold[1][i];
    tx[5] = tx[5] ^ 32'd1;
    send_round(8, 1'b0, 1'b0);
    finish_round(1'b0, 1'b1, 3'd5, 1'b1, 2);
    for (int i = 0; i < 8; i++) tx[i] = gold[2][i];
    send_round(8, 1'b0, 1'b0);
    finish_round(1'b0, 1'b0, 3'd0, 1'b1, 3);

    // T4: words 2 and 6 corrupted, then a clean round seeded from them
    for (int i = 0; i < 8; i++) tx[i] = gold[3][i];
    tx[2] = tx[2] ^ 32'h0000_0100;
    tx[6] = tx[6] ^ 32'h8000_0000;
    send_round(8, 1'b0, 1'b0);
    finish_round(1'b0, 1'b1, 3'd2, 1'b1, 4);
    for (int i = 0; i < 8; i++) m[i] = tx[i];
    model_round();
    for (int i = 0; i < 8; i++) tx[i] = m[i];
    send_round(8, 1'b0, 1'b0);
    finish_round(1'b1, 1'b1, 3'd2, 1'b1, 5);

    // T6: reset after 4 accepted words restarts from o[i]=i
    for (int i = 0; i < 8; i++) tx[i] = gold[0][i];
    send_round(4, 1'b0, 1'b0);
    do_reset();
    wait_ready(n);
    check_val("t6_busy_cycles", 32'(n), 32'd64);
    send_round(8, 1'b0, 1'b0);
    finish_round(1'b1, 1'b1, 3'd0, 1'b0, 1);

    // T5: in_valid held through COMPUTE, random gaps; then 5 rounds for RCW=2 wrap
    do_reset();
    in_valid = 1'b1;
    in_data  = gold[0][0];
    acc0 = acc_cnt;
    wait_ready(n);
    check_val("t5_busy_cycles", 32'(n), 32'd64);
    check_val("t5_no_early_accept", 32'(acc_cnt - acc0), 32'd0);
    for (int i = 0; i < 8; i++) tx[i] = gold[0][i];
    send_round(8, 1'b1, 1'b1);
    finish_round(1'b1, 1'b1, 3'd0, 1'b0, 1);
    check_val("t5_accepts", 32'(acc_cnt - acc0), 32'd8);
    for (int r = 1; r < 5; r++) begin
      for (int i = 0; i < 8; i++) tx[i] = gold[r][i];
      send_round(8, 1'b1, 1'b0);
      finish_round(1'b1, 1'b1, 3'd0, 1'b0, r + 1);
    end
    check_val("rcw2_round_cnt", 32'(round_cnt2), 32'd1);
    check_val("rcw2_round_ok", 32'(round_ok2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
